// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS sequencing FSM: fetch/memory handshakes, IR/PC/RF write strobes,
// and cycle/retired-instruction counters. States: INIT reset | IF fetch req | IW wait word |
// ID decode | EX execute | ST store | LD load req | RDW wait load data | WB reg write.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             inst_nop,
    input  logic             branch_cond,
    output logic             inst_req_valid,
    input  logic             inst_req_ready,
    input  logic             inst_valid,
    output logic             inst_ready,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_req_ready,
    input  logic             read_data_valid,
    output logic             read_data_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             unknown_inst,
    output logic [8:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt
);
    typedef enum logic [3:0] {
        S_INIT, S_IF, S_IW, S_ID, S_EX, S_ST, S_LD, S_RDW, S_WB
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b, OP_LUI   = 6'h0f,
                           OP_LW    = 6'h23, OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADDU = 6'h21,
                           FN_OR  = 6'h25, FN_SLT = 6'h2a;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, inst_q;
    logic             retire;
    logic             is_rtype, is_jr, known;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);

    always_comb begin
        known = 1'b0;
        if (is_rtype) begin
            known = (funct == FN_SLL) || (funct == FN_ADDU) || (funct == FN_OR) ||
                    (funct == FN_SLT) || (funct == FN_JR);
        end else begin
            case (opcode)
                OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_LUI, OP_LW, OP_SW: known = 1'b1;
                default:              known = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        inst_req_valid  = 1'b0;
        inst_ready      = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        read_data_ready = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write       = 1'b0;
        unknown_inst    = 1'b0;
        retire          = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) state_d = S_IW;
            end
            S_IW: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    ir_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                pc_write = 1'b1;
                // nop takes precedence: IR==0 also decodes as sll but must not execute
                if (inst_nop || !known) begin
                    unknown_inst = !inst_nop;
                    retire       = 1'b1;
                    state_d      = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_jr || opcode == OP_J) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    pc_write = branch_cond;
                    retire   = 1'b1;
                    state_d  = S_IF;
                end else if (opcode == OP_JAL) begin
                    pc_write = 1'b1;
                    state_d  = S_WB;
                end else if (opcode == OP_LW) begin
                    state_d = S_LD;
                end else if (opcode == OP_SW) begin
                    state_d = S_ST;
                end else begin
                    state_d = S_WB;
                end
            end
            S_ST: begin
                mem_write = 1'b1;
                if (mem_req_ready) begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_LD: begin
                mem_read = 1'b1;
                if (mem_req_ready) state_d = S_RDW;
            end
            S_RDW: begin
                read_data_ready = 1'b1;
                if (read_data_valid) state_d = S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_q + 1'b1;
            if (retire) inst_q <= inst_q + 1'b1;
        end
    end

    assign state     = 9'd1 << state_q;
    assign cycle_cnt = cycle_q;
    assign inst_cnt  = inst_q;
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main sequencing FSM for the multi-cycle MIPS datapath. It decodes opcode/funct only far enough to choose the next state.
- Drives the fetch and memory handshakes, plus the register-file, IR and PC write enables.
- Per-instruction datapath controls (ALU op, mux selects) come from the combinational decoder. This block decides only *when* each stage fires.
- Also maintains cycle and retired-instruction counters for performance reporting.

Parameters:
- CNT_W, 32, width of cycle_cnt and inst_cnt.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from ID onward
- funct  in  6  IR[5:0]
- inst_nop  in  1  IR == 32'h0
- branch_cond  in  1  ALU compare result; 1 = beq/bne taken; sampled in EX
- inst_req_valid  out  1  fetch request valid
- inst_req_ready  in  1  memory accepts fetch request
- inst_valid  in  1  fetched word present
- inst_ready  out  1  controller accepts fetched word
- mem_read  out  1  load request valid
- mem_write  out  1  store request valid
- mem_req_ready  in  1  memory accepts load/store request
- read_data_valid  in  1  load data present
- read_data_ready  out  1  controller accepts load data
- ir_write  out  1  latch IR
- pc_write  out  1  update PC
- reg_write  out  1  register-file write enable
- unknown_inst  out  1  one-cycle pulse in ID for an unsupported encoding
- state  out  9  one-hot state: [0]INIT [1]IF [2]IW [3]ID [4]EX [5]ST [6]LD [7]RDW [8]WB
- cycle_cnt  out  CNT_W  cycles since reset
- inst_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset:
  - state=INIT (9'b1); counters=0.
  - All handshake outputs and write enables are 0.
  - Reset mid-handshake abandons any outstanding request; no retire is counted.
- Supported set:
  - R-type: sll, addu, or, slt, jr.
  - I/J-type: addiu, lw, sw, bne, beq, j, jal, lui, slti, sltiu.
  - Anything else is unknown.
- INIT -> IF unconditionally.
- IF:
  - inst_req_valid=1.
  - On inst_req_ready -> IW; otherwise hold.
- IW:
  - inst_ready=1.
  - On inst_valid: ir_write=1 (same cycle) -> ID; otherwise hold.
- ID:
  - pc_write=1 (PC+4) unconditionally.
  - If inst_nop or unknown: -> IF, retire. unknown_inst=1 only for the unknown case, never for nop.
  - Otherwise -> EX.
- EX:
  - j, jr -> IF, pc_write=1, retire.
  - beq/bne -> IF, retire; pc_write=branch_cond.
  - jal -> WB with pc_write=1 (target written; link value is captured by the datapath).
  - lw -> LD; sw -> ST.
  - All remaining ALU instructions -> WB.
- ST:
  - mem_write=1.
  - On mem_req_ready -> IF, retire; otherwise hold.
- LD:
  - mem_read=1.
  - On mem_req_ready -> RDW; otherwise hold.
- RDW:
  - read_data_ready=1.
  - On read_data_valid -> WB; otherwise hold.
- WB: reg_write=1 for exactly one cycle -> IF, retire.
- Output timing:
  - Handshake outputs are Moore (from state only); they never depend combinationally on the ready/valid inputs.
  - ir_write and pc_write are the only Mealy outputs.
  - A handshake completes in any cycle where valid and ready are both 1, including the first cycle of the state.
  - Requests stay asserted until accepted.
- Retire:
  - inst_cnt += 1 on the clock edge of each retiring transition into IF, at most one per instruction.
  - cycle_cnt += 1 every cycle rst=0.
  - Both counters wrap modulo 2^CNT_W.
- Latency (zero-wait memory): ALU/lui/jal = 5 cycles (IF,IW,ID,EX,WB); sw = 5; lw = 7; j/jr/branch/nop = 4 or 3.
- Simultaneous events: inst_valid arriving while in IF is ignored, since inst_ready=0 there.

Test Plan:
- Reset: hold rst 3 cycles mid-LD with mem_read=1 -> next cycle state=9'b1, all outputs 0, counters 0; following cycle state=IF, inst_req_valid=1.
- addiu, zero-wait memory -> states IF,IW,ID,EX,WB,IF; ir_write in IW; pc_write in ID only; reg_write exactly 1 cycle in WB; inst_cnt=1, cycle_cnt=6 at return to IF (from first IF after INIT).
- lw with mem_req_ready low 3 cycles and read_data_valid delayed 2 cycles -> mem_read held 4 cycles, read_data_ready held 3 cycles, then WB with reg_write=1.
- beq, branch_cond=0 then bne, branch_cond=1 -> pc_write asserted in ID for both, in EX only for the bne; inst_cnt=2; reg_write never asserted.
- IR=32'h0 then opcode=6'b111111 -> nop: ID->IF with unknown_inst=0; unknown: ID->IF with unknown_inst pulsed once; inst_cnt+=2; no EX visited.
- Counter wrap: CNT_W=4 parameterization, run 20 cycles -> cycle_cnt wraps 15->0, reports 4 at cycle 20; sw with inst_req_ready stalled 5 cycles in IF -> inst_req_valid held high throughout, no glitch.
